// File: rtl/ifu_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ifu_fetch_ctrl_pkg
// Shared definitions for the instruction-fetch sequencing controller:
//   - default PC / instruction widths
//   - IFU_RESET_PC, the first fetch address after reset
//   - the 2-bit fetch FSM state encodings (REQ, WAIT, HOLD)
// ----------------------------------------------------------------------------
package ifu_fetch_ctrl_pkg;

    localparam int          IFU_PC_WIDTH    = 32;
    localparam int          IFU_INSTR_WIDTH = 32;
    localparam logic [31:0] IFU_RESET_PC    = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

endpackage : ifu_fetch_ctrl_pkg

// File: rtl/ifu_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// ifu_fetch_ctrl
// Sequencing controller for the instruction-fetch stage. Owns the fetch PC,
// issues one outstanding request at a time, buffers the returned instruction
// and presents it to the next-PC / mini-decode logic and to the IF/ID register.
// EXU redirects override everything else.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   ifu_req_valid_o/ready_i      fetch request handshake
//   ifu_req_pc_o                 fetch address (word aligned)
//   ifu_rsp_valid_i/instr_i/err_i  fetch response (one per accepted request)
//   fetch_pc_o, fetch_instr_o    buffered PC / instruction to next-PC logic
//   pc_next_i                    predicted next PC from next-PC logic
//   ifid_valid_o/ready_i         handshake to the IF/ID register
//   ifid_instr_o/pc_o/err_o      payload to the IF/ID register
//   redirect_valid_i/pc_i        EXU flush and redirect target
// ----------------------------------------------------------------------------
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int                   PC_WIDTH    = IFU_PC_WIDTH,
    parameter int                   INSTR_WIDTH = IFU_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(IFU_RESET_PC)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    output logic                    ifu_req_valid_o,
    input  logic                    ifu_req_ready_i,
    output logic [PC_WIDTH-1:0]     ifu_req_pc_o,

    input  logic                    ifu_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0]  ifu_rsp_instr_i,
    input  logic                    ifu_rsp_err_i,

    output logic [PC_WIDTH-1:0]     fetch_pc_o,
    output logic [INSTR_WIDTH-1:0]  fetch_instr_o,
    input  logic [PC_WIDTH-1:0]     pc_next_i,

    output logic                    ifid_valid_o,
    input  logic                    ifid_ready_i,
    output logic [INSTR_WIDTH-1:0]  ifid_instr_o,
    output logic [PC_WIDTH-1:0]     ifid_pc_o,
    output logic                    ifid_err_o,

    input  logic                    redirect_valid_i,
    input  logic [PC_WIDTH-1:0]     redirect_pc_i
);

    // Clears bits [1:0] of any incoming target so fetches stay word aligned.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    ifu_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    buf_pc_q, buf_pc_d;
    logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic                   buf_err_q, buf_err_d;
    logic                   drop_q, drop_d;
    logic                   req_fire;
    logic                   ifid_fire;

    // A redirect kills both handshakes in the same cycle. The request valid
    // is also gated by rst_i because the reset state is REQ.
    assign ifu_req_valid_o = (state_q == ST_REQ) && !redirect_valid_i && !rst_i;
    assign ifid_valid_o    = (state_q == ST_HOLD) && !redirect_valid_i;
    assign req_fire        = ifu_req_valid_o && ifu_req_ready_i;
    assign ifid_fire       = ifid_valid_o && ifid_ready_i;

    assign ifu_req_pc_o  = pc_q;
    assign fetch_pc_o    = buf_pc_q;
    assign fetch_instr_o = buf_instr_q;
    assign ifid_pc_o     = buf_pc_q;
    assign ifid_instr_o  = buf_instr_q;
    assign ifid_err_o    = buf_err_q;

    // State and buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            buf_err_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_err_q   <= buf_err_d;
            drop_q      <= drop_d;
        end
    end

    // Next-state logic. A redirect while a request is outstanding and no
    // response has arrived arms drop_q so the stale response is swallowed;
    // since only one request is ever outstanding, drop_q is a single flag.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_err_d   = buf_err_q;
        drop_d      = drop_q;

        if (redirect_valid_i) begin
            pc_d = redirect_pc_i & ALIGN_MASK;
            unique case (state_q)
                ST_REQ: state_d = ST_REQ;
                ST_WAIT: begin
                    if (ifu_rsp_valid_i) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                ST_HOLD: state_d = ST_REQ;
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        buf_pc_d = pc_q;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ifu_rsp_valid_i) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            buf_instr_d = ifu_rsp_instr_i;
                            buf_err_d   = ifu_rsp_err_i;
                            state_d     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (ifid_fire) begin
                        pc_d    = pc_next_i & ALIGN_MASK;
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Responses are only legal while a request is outstanding.
    rsp_only_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
        !(ifu_rsp_valid_i && (state_q != ST_WAIT)));
`endif

endmodule : ifu_fetch_ctrl

// File: tb/tb_ifu_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch_ctrl
// Self-checking bench for ifu_fetch_ctrl. Each record holds one cycle of
// inputs plus the outputs expected in that cycle (before the clock edge that
// commits it). Inputs are driven on the falling edge and outputs sampled 1ns
// later; the next rising edge then advances the design.
// ----------------------------------------------------------------------------
module tb_ifu_fetch_ctrl;

    typedef struct {
        logic        rst;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_instr;
        logic        rsp_err;
        logic [31:0] pc_next;
        logic        ifid_ready;
        logic        redir_valid;
        logic [31:0] redir_pc;
        logic        exp_req_valid;
        logic [31:0] exp_req_pc;
        logic        exp_ifid_valid;
        logic [31:0] exp_buf_pc;
        logic [31:0] exp_buf_instr;
        logic        exp_err;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ifu_req_valid_o;
    logic        ifu_req_ready_i = 1'b0;
    logic [31:0] ifu_req_pc_o;
    logic        ifu_rsp_valid_i = 1'b0;
    logic [31:0] ifu_rsp_instr_i = '0;
    logic        ifu_rsp_err_i = 1'b0;
    logic [31:0] fetch_pc_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] pc_next_i = '0;
    logic        ifid_valid_o;
    logic        ifid_ready_i = 1'b0;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic        ifid_err_o;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    ifu_fetch_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ifu_req_valid_o  (ifu_req_valid_o),
        .ifu_req_ready_i  (ifu_req_ready_i),
        .ifu_req_pc_o     (ifu_req_pc_o),
        .ifu_rsp_valid_i  (ifu_rsp_valid_i),
        .ifu_rsp_instr_i  (ifu_rsp_instr_i),
        .ifu_rsp_err_i    (ifu_rsp_err_i),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_instr_o    (fetch_instr_o),
        .pc_next_i        (pc_next_i),
        .ifid_valid_o     (ifid_valid_o),
        .ifid_ready_i     (ifid_ready_i),
        .ifid_instr_o     (ifid_instr_o),
        .ifid_pc_o        (ifid_pc_o),
        .ifid_err_o       (ifid_err_o),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(
        input logic rst, input logic rdy, input logic rv,
        input logic [31:0] ri, input logic re, input logic [31:0] pn,
        input logic ir, input logic dv, input logic [31:0] dp,
        input logic e_rv, input logic [31:0] e_rpc, input logic e_iv,
        input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_err);
        vec_t v;
        v.rst = rst;          v.req_ready = rdy;     v.rsp_valid = rv;
        v.rsp_instr = ri;     v.rsp_err = re;        v.pc_next = pn;
        v.ifid_ready = ir;    v.redir_valid = dv;    v.redir_pc = dp;
        v.exp_req_valid = e_rv;   v.exp_req_pc = e_rpc;
        v.exp_ifid_valid = e_iv;  v.exp_buf_pc = e_pc;
        v.exp_buf_instr = e_ins;  v.exp_err = e_err;
        return v;
    endfunction

    task automatic checkField(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkField("req_valid",   idx, 32'(ifu_req_valid_o), 32'(v.exp_req_valid));
        checkField("req_pc",      idx, ifu_req_pc_o,         v.exp_req_pc);
        checkField("ifid_valid",  idx, 32'(ifid_valid_o),    32'(v.exp_ifid_valid));
        checkField("ifid_pc",     idx, ifid_pc_o,            v.exp_buf_pc);
        checkField("ifid_instr",  idx, ifid_instr_o,         v.exp_buf_instr);
        checkField("ifid_err",    idx, 32'(ifid_err_o),      32'(v.exp_err));
        checkField("fetch_pc",    idx, fetch_pc_o,           v.exp_buf_pc);
        checkField("fetch_instr", idx, fetch_instr_o,        v.exp_buf_instr);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk_i);
        rst_i            = v.rst;
        ifu_req_ready_i  = v.req_ready;
        ifu_rsp_valid_i  = v.rsp_valid;
        ifu_rsp_instr_i  = v.rsp_instr;
        ifu_rsp_err_i    = v.rsp_err;
        pc_next_i        = v.pc_next;
        ifid_ready_i     = v.ifid_ready;
        redirect_valid_i = v.redir_valid;
        redirect_pc_i    = v.redir_pc;
        #1;
        checkOutput(v, idx);
    endtask

    initial begin
        // rst rdy rv instr err pc_next ir dv dpc | req_v req_pc ifid_v buf_pc buf_instr err
        // Reset, then basic fetch of 0x13 at the reset PC.
        tbl.push_back(mk(1,0,0,32'h0,0,32'h0,0,0,32'h0,        0,32'h8000_0000,0,32'h0,32'h0,0));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h8000_0000,0,32'h0,32'h0,0));
        tbl.push_back(mk(0,0,1,32'h13,0,32'h0,0,0,32'h0,       0,32'h8000_0000,0,32'h8000_0000,32'h0,0));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h8000_0004,1,0,32'h0,0,32'h8000_0000,1,32'h8000_0000,32'h13,0));
        // Memory not ready for 3 cycles: request held stable.
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h8000_0004,0,32'h8000_0000,32'h13,0));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h8000_0004,0,32'h8000_0000,32'h13,0));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h8000_0004,0,32'h8000_0000,32'h13,0));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h8000_0004,0,32'h8000_0000,32'h13,0));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,0,0,32'h0,        0,32'h8000_0004,0,32'h8000_0004,32'h13,0));
        tbl.push_back(mk(0,0,1,32'h0010_0093,0,32'h0,0,0,32'h0,0,32'h8000_0004,0,32'h8000_0004,32'h13,0));
        // IF/ID stalls 4 cycles in HOLD, then accepts.
        tbl.push_back(mk(0,1,0,32'h0,0,32'h8000_0008,0,0,32'h0,0,32'h8000_0004,1,32'h8000_0004,32'h0010_0093,0));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h8000_0008,0,0,32'h0,0,32'h8000_0004,1,32'h8000_0004,32'h0010_0093,0));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h8000_0008,0,0,32'h0,0,32'h8000_0004,1,32'h8000_0004,32'h0010_0093,0));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h8000_0008,0,0,32'h0,0,32'h8000_0004,1,32'h8000_0004,32'h0010_0093,0));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h8000_0008,1,0,32'h0,0,32'h8000_0004,1,32'h8000_0004,32'h0010_0093,0));
        // Redirect in WAIT with no response: later response dropped.
        tbl.push_back(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h8000_0008,0,32'h8000_0004,32'h0010_0093,0));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,0,1,32'h8000_0102,0,32'h8000_0008,0,32'h8000_0008,32'h0010_0093,0));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,0,0,32'h0,        0,32'h8000_0100,0,32'h8000_0008,32'h0010_0093,0));
        tbl.push_back(mk(0,0,1,32'hDEAD_BEEF,0,32'h0,0,0,32'h0,0,32'h8000_0100,0,32'h8000_0008,32'h0010_0093,0));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h8000_0100,0,32'h8000_0008,32'h0010_0093,0));
        // Redirect coincident with response: dropped, drop flag stays clear.
        tbl.push_back(mk(0,0,1,32'h1111_1111,0,32'h0,0,1,32'h2000,0,32'h8000_0100,0,32'h8000_0100,32'h0010_0093,0));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h2000,0,32'h8000_0100,32'h0010_0093,0));
        tbl.push_back(mk(0,0,1,32'h2222_2222,0,32'h0,0,0,32'h0,0,32'h2000,0,32'h2000,32'h0010_0093,0));
        // Misaligned predicted PC is forced word aligned.
        tbl.push_back(mk(0,0,0,32'h0,0,32'h2007,1,0,32'h0,     0,32'h2000,1,32'h2000,32'h2222_2222,0));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h2004,0,32'h2000,32'h2222_2222,0));
        // Error response, then redirect in HOLD and redirect in REQ.
        tbl.push_back(mk(0,0,1,32'h0,1,32'h0,0,0,32'h0,        0,32'h2004,0,32'h2004,32'h2222_2222,0));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h2008,0,0,32'h0,     0,32'h2004,1,32'h2004,32'h0,1));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h2008,1,1,32'h3001,  0,32'h2004,0,32'h2004,32'h0,1));
        tbl.push_back(mk(0,0,0,32'h0,0,32'h0,0,1,32'h4000,     0,32'h3000,0,32'h2004,32'h0,1));
        tbl.push_back(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,        1,32'h4000,0,32'h2004,32'h0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], i);
        end

        // Asynchronous reset in the middle of WAIT: outputs return immediately.
        @(negedge clk_i);
        ifu_req_ready_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput(mk(1,0,0,32'h0,0,32'h0,0,0,32'h0, 0,32'h8000_0000,0,32'h0,32'h0,0), 100);

        // Back-to-back redirects in WAIT arm only a single drop.
        applyStimulus(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,       1,32'h8000_0000,0,32'h0,32'h0,0), 101);
        applyStimulus(mk(0,0,0,32'h0,0,32'h0,0,1,32'h5000,    0,32'h8000_0000,0,32'h8000_0000,32'h0,0), 102);
        applyStimulus(mk(0,0,0,32'h0,0,32'h0,0,1,32'h6000,    0,32'h5000,0,32'h8000_0000,32'h0,0), 103);
        applyStimulus(mk(0,0,1,32'hAAAA_AAAA,0,32'h0,0,0,32'h0,0,32'h6000,0,32'h8000_0000,32'h0,0), 104);
        applyStimulus(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,       1,32'h6000,0,32'h8000_0000,32'h0,0), 105);
        applyStimulus(mk(0,0,1,32'h33,0,32'h0,0,0,32'h0,      0,32'h6000,0,32'h6000,32'h0,0), 106);
        applyStimulus(mk(0,0,0,32'h0,0,32'h6004,1,0,32'h0,    0,32'h6000,1,32'h6000,32'h33,0), 107);
        applyStimulus(mk(0,0,0,32'h0,0,32'h0,0,0,32'h0,       1,32'h6004,0,32'h6000,32'h33,0), 108);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ifu_fetch_ctrl
